// File: rtl/bcd_counter_4_pkg.sv
// Shared definitions for the registered modulo digit counter.
// Cascaded digit counters import this package so they agree on the
// counter width, the default decade limit and the next-state selection.
package bcd_counter_4_pkg;

    // Width of one digit counter.
    localparam int CNT_W = 4;

    // Default last count before wrap: a decimal (BCD) digit.
    localparam logic [CNT_W-1:0] BCD_MAX = 4'd9;

    // Largest legal limit: plain binary counting.
    localparam logic [CNT_W-1:0] BIN_MAX = 4'd15;

    // Which source feeds the count register on the next edge.
    typedef enum logic [2:0] {
        SEL_HOLD     = 3'd0,  // keep q
        SEL_CLR      = 3'd1,  // synchronous clear
        SEL_LOAD     = 3'd2,  // legal parallel load
        SEL_LOAD_BAD = 3'd3,  // load above limit: zero and flag
        SEL_INC      = 3'd4,  // q + 1 from the incrementor
        SEL_WRAP     = 3'd5,  // q == limit: back to zero with wrap pulse
        SEL_RECOVER  = 3'd6   // q above limit: back to zero, no pulse
    } next_sel_e;

    // Priority encoder for the next-state mux. Reset is handled in the
    // flop itself, so this only orders clear > load > enable > hold.
    function automatic next_sel_e pick_next(
        input logic clr,
        input logic ld,
        input logic en,
        input logic d_over,
        input logic at_max,
        input logic above_max
    );
        next_sel_e sel;
        sel = SEL_HOLD;
        if (clr) begin
            sel = SEL_CLR;
        end else if (ld) begin
            sel = d_over ? SEL_LOAD_BAD : SEL_LOAD;
        end else if (en) begin
            if (at_max) begin
                sel = SEL_WRAP;
            end else if (above_max) begin
                sel = SEL_RECOVER;
            end else begin
                sel = SEL_INC;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/Incrementor_4.sv
// Four-bit half-adder ripple incrementor: o_sum = i_a + 1.
// Each stage is a half adder whose second input is the carry from the
// stage below; stage 0 is fed a constant 1.
module Incrementor_4 (
    input  logic [3:0] i_a,
    output logic [3:0] o_sum,
    output logic       o_cout
);

    // Ripple carry chain; w_carry[0] is the injected +1.
    logic [4:0] w_carry;

    assign w_carry[0] = 1'b1;

    // One half adder per bit: sum is XOR, carry-out is AND.
    for (genvar i = 0; i < 4; i++) begin : g_half_adder
        assign o_sum[i]     = i_a[i] ^ w_carry[i];
        assign w_carry[i+1] = i_a[i] & w_carry[i];
    end

    assign o_cout = w_carry[4];

endmodule

// File: rtl/bcd_counter_4.sv
// Registered 4-bit modulo counter with clear, load, count enable,
// programmable wrap limit and a combinational terminal count for
// ripple-enable cascading of decade digits.
//
// Handshake-free block: every control input is sampled on each rising
// clk edge with priority rst_n=0 > clr > ld > en > hold. tc is a
// same-cycle output so a downstream digit enabled by tc steps on the
// same edge as this digit wraps.
module bcd_counter_4
    import bcd_counter_4_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       ld,
    input  logic       en,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       tc,
    output logic       wrap,
    output logic       err
);

    // State registers.
    logic [CNT_W-1:0] r_q;
    logic             r_wrap;
    logic             r_err;

    // Next-state path.
    logic [CNT_W-1:0] w_q_inc;
    logic             w_inc_cout_unused;  // wrap is governed by MAX, not the carry
    logic             w_at_max;
    logic             w_above_max;
    logic             w_d_over;
    next_sel_e        w_sel;
    logic [CNT_W-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_err_next;

    // q + 1 through the half-adder ripple chain.
    Incrementor_4 u_inc (
        .i_a    (r_q),
        .o_sum  (w_q_inc),
        .o_cout (w_inc_cout_unused)
    );

    // Limit comparators for the count and for the load value.
    always_comb begin
        w_at_max    = (r_q == MAX);
        w_above_max = (r_q > MAX);
        w_d_over    = (d > MAX);
    end

    // Prioritised selection of the next-state source.
    always_comb begin
        w_sel = pick_next(clr, ld, en, w_d_over, w_at_max, w_above_max);
    end

    // Next-state mux for q, wrap and the sticky error flag.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        w_err_next  = r_err;
        unique case (w_sel)
            SEL_CLR: begin
                w_q_next   = '0;
                w_err_next = 1'b0;
            end
            SEL_LOAD: begin
                w_q_next = d;
            end
            SEL_LOAD_BAD: begin
                w_q_next   = '0;
                w_err_next = 1'b1;
            end
            SEL_INC: begin
                w_q_next = w_q_inc;
            end
            SEL_WRAP: begin
                w_q_next    = '0;
                w_wrap_next = 1'b1;
            end
            SEL_RECOVER: begin
                w_q_next = '0;
            end
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    // Count, wrap-pulse and error flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            r_err  <= w_err_next;
        end
    end

    // Terminal count is gated by en so an idle digit never ripples.
    always_comb begin
        tc = en & w_at_max;
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule
